// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT registers on the data bus,
// iterative multiply (one 32x4 product per cycle) sequenced by a two-state FSM.
module fact_accel #(
    parameter int MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy
);

    // Bus handshake: a write is a single-cycle strobe (we with a/wd valid at the
    // rising edge); there is no ready, so writes that arrive while BUSY are dropped.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_N      = 2'b00;
    localparam logic [1:0] ADDR_GO     = 2'b01;
    localparam logic [1:0] ADDR_STATUS = 2'b10;
    localparam logic [1:0] ADDR_RESULT = 2'b11;

    localparam logic [31:0] MAX_N_W = 32'(MAX_N);

    state_t      state, state_next;
    logic [3:0]  n_reg, n_next;
    logic        go_reg, go_next;
    logic        done, done_next;
    logic        err, err_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] prod, prod_next;
    logic [31:0] result, result_next;

    logic        wr_n;
    logic        wr_go;
    logic        n_ok;
    logic [31:0] prod_mul;

    assign wr_n     = we && (a == ADDR_N);
    assign wr_go    = we && (a == ADDR_GO);
    assign n_ok     = ({28'b0, n_reg} <= MAX_N_W);
    assign prod_mul = prod * {28'b0, cnt};
    assign busy     = (state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n_reg  <= 4'd0;
            go_reg <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= 4'd0;
            prod   <= 32'd0;
            result <= 32'd0;
        end else begin
            state  <= state_next;
            n_reg  <= n_next;
            go_reg <= go_next;
            done   <= done_next;
            err    <= err_next;
            cnt    <= cnt_next;
            prod   <= prod_next;
            result <= result_next;
        end
    end

    always_comb begin
        state_next  = state;
        n_next      = n_reg;
        go_next     = go_reg;
        done_next   = done;
        err_next    = err;
        cnt_next    = cnt;
        prod_next   = prod;
        result_next = result;

        case (state)
            IDLE: begin
                if (wr_n) begin
                    n_next = wd[3:0];
                end
                if (wr_go) begin
                    if (wd[0]) begin
                        go_next   = 1'b1;
                        done_next = 1'b0;
                        err_next  = 1'b0;
                        cnt_next  = n_reg;
                        prod_next = 32'd1;
                        if (n_ok) begin
                            state_next = BUSY;
                        end else begin
                            // Out-of-range N completes immediately with an error.
                            err_next    = 1'b1;
                            done_next   = 1'b1;
                            result_next = 32'd0;
                            go_next     = 1'b0;
                        end
                    end else begin
                        go_next = 1'b0;
                    end
                end
            end

            BUSY: begin
                if (cnt > 4'd1) begin
                    prod_next = prod_mul;
                    cnt_next  = cnt - 4'd1;
                end else begin
                    // N=0 and N=1 land here on the first BUSY edge with prod=1.
                    result_next = prod;
                    done_next   = 1'b1;
                    go_next     = 1'b0;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            ADDR_N:      rd = {28'b0, n_reg};
            ADDR_GO:     rd = {31'b0, go_reg};
            ADDR_STATUS: rd = {30'b0, err, done};
            ADDR_RESULT: rd = result;
            default:     rd = 32'd0;
        endcase
    end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 Parameter MAX_N, default 12: largest n accepted; 12! is the largest factorial that fits in 32 bits.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port we, input, 1: write strobe from the data-memory bus (we_dm after address decode selects this block).
REQ-005 Port a, input, 2: register select, taken from alu_out[3:2].
REQ-006 Port wd, input, 32: write data (wd_dm).
REQ-007 Port rd, output, 32: read data returned to the core's rd_dm mux.
REQ-008 Port busy, output, 1: high while the FSM is in BUSY; debug/observation only.

Function
REQ-009 The register map SHALL be: a=00 N (write wd[3:0]; read {28'b0,N}); a=01 GO (write wd[0]; read {31'b0,go_reg}); a=10 STATUS (read-only {30'b0,err,done}); a=11 RESULT (read-only).
REQ-010 rd SHALL be a combinational mux of registered state selected by a, independent of we.
REQ-011 Writes to STATUS or RESULT SHALL be ignored.
REQ-012 The FSM SHALL have exactly two states, IDLE and BUSY; busy=1 iff the state is BUSY.
REQ-013 A write of N in IDLE SHALL update N at that edge; a write of N in BUSY SHALL be ignored.
REQ-014 A write of GO with wd[0]=1 in IDLE SHALL, at that edge: set go_reg=1, clear done and err, load cnt=N and prod=1.
REQ-015 At the REQ-014 edge, if N<=MAX_N, the state SHALL become BUSY.
REQ-016 At the REQ-014 edge, if N>MAX_N, the state SHALL stay IDLE, with err=1, done=1, RESULT=0 and go_reg=0.
REQ-017 A write of GO with wd[0]=0 SHALL clear go_reg only; it SHALL NOT abort a computation.
REQ-018 A write of GO (either value) in BUSY SHALL be ignored.
REQ-019 In BUSY with cnt>1, each edge SHALL set prod=prod*cnt, truncated to 32 bits, and cnt=cnt-1.
REQ-020 In BUSY with cnt<=1, the edge SHALL set RESULT=prod, done=1, go_reg=0 and state=IDLE.
REQ-021 Latency: done SHALL rise exactly max(N,1) edges after the GO edge; N=0 and N=1 both give RESULT=1 after 1 edge.
REQ-022 RESULT SHALL hold its previous value throughout BUSY; prod SHALL NOT be visible on rd.
REQ-023 done and err SHALL remain set until the next accepted GO or reset; reads SHALL NOT clear them.
REQ-024 If we is asserted at the same edge as completion (REQ-020), completion SHALL take effect and the write SHALL be treated as occurring in BUSY, i.e. ignored.
REQ-025 The multiplier SHALL be a single 32x4 product per cycle; no multi-cycle multiplier is permitted.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, N=0, go_reg=0, done=0, err=0, cnt=0, prod=0, RESULT=0, busy=0; rd therefore reads 0 at every address.
REQ-027 rst SHALL take priority over every write and over completion.
REQ-028 rst asserted during BUSY SHALL abort the computation, leaving done=0 and RESULT=0.

Verification
REQ-029 Sequence: write N=5, then GO=1 at edge E -> busy=1 on edges E..E+4, STATUS=01 and RESULT=0x00000078 after edge E+5.
REQ-030 Sequence: N=0, then GO -> done after 1 edge, RESULT=0x00000001; repeat with N=1 -> same result.
REQ-031 Sequence: N=12, then GO -> after 12 edges RESULT=0x1C8CFC00, err=0.
REQ-032 Sequence: N=13, then GO -> same edge leaves IDLE unchanged, STATUS=11, RESULT=0, busy never asserts.
REQ-033 Sequence: N=6 with GO; at GO+2 write N=3 and GO=1 -> both ignored; RESULT=0x000002D0 (720) after 6 edges, N still reads 6.
REQ-034 Sequence: N=7 with GO; rst pulsed at GO+3 -> all registers read 0; then N=4 with GO -> RESULT=0x00000018 after 4 edges.
